// File: rtl/score_keeper.sv
// Scoring engine: qualifies colour-button hits against the one-hot ball position and keeps per-player tallies.
// Optional feature: define SCORE_UNDO_EN to let a green-button edge take back the last point scored.
module score_keeper #(
  parameter int NUM_POS   = 10,
  parameter int RED_POS   = 2,
  parameter int BLUE_POS  = 9,
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 9,
  parameter int COOLDOWN  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         color,
  input  logic [NUM_POS-1:0] state,
  input  logic               clr,
  output logic [1:0]         score_pulse,
  output logic [SCORE_W-1:0] red_score,
  output logic [SCORE_W-1:0] blue_score,
  output logic [1:0]         winner,
  output logic               busy
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [NUM_POS-1:0] RED_MASK  = NUM_POS'(1) << RED_POS;
  localparam logic [NUM_POS-1:0] BLUE_MASK = NUM_POS'(1) << BLUE_POS;
  localparam logic [SCORE_W-1:0] LAST_POINT = SCORE_W'(WIN_SCORE - 1);

  typedef enum logic [1:0] {PLAY, COOL, WON} fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       hit;
  logic [1:0]       hit_q;
  logic [1:0]       hit_prev;
  logic [1:0]       hit_ev;

  // Hits are registered first and edge-detected on the registered copy,
  // which is what places the score one cycle after the input change.
  always_comb begin
    hit[1] = (color == 3'b100) && (state == RED_MASK);
    hit[0] = (color == 3'b100) && (state == BLUE_MASK);
    hit_ev = hit_q & ~hit_prev;
  end

`ifdef SCORE_UNDO_EN
  logic       green_q;
  logic       green_prev;
  logic [1:0] last_scorer;
  logic       undo_ev;

  assign undo_ev = green_q & ~green_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      green_q    <= 1'b0;
      green_prev <= 1'b0;
    end else begin
      green_q    <= (color == 3'b001);
      green_prev <= green_q;
    end
  end
`endif

  assign busy = (fsm == COOL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= PLAY;
      cnt         <= '0;
      hit_q       <= '0;
      hit_prev    <= '0;
      score_pulse <= '0;
      red_score   <= '0;
      blue_score  <= '0;
      winner      <= '0;
`ifdef SCORE_UNDO_EN
      last_scorer <= '0;
`endif
    end else begin
      hit_q       <= hit;
      hit_prev    <= hit_q;
      score_pulse <= '0;
      if (clr) begin
        fsm        <= PLAY;
        cnt        <= '0;
        red_score  <= '0;
        blue_score <= '0;
        winner     <= '0;
`ifdef SCORE_UNDO_EN
        last_scorer <= '0;
`endif
      end else begin
        case (fsm)
          PLAY: begin
            if (hit_ev[1]) begin
              red_score   <= red_score + 1'b1;
              score_pulse <= 2'b10;
`ifdef SCORE_UNDO_EN
              last_scorer <= 2'b10;
`endif
              if (red_score == LAST_POINT) begin
                winner <= 2'b10;
                fsm    <= WON;
              end else begin
                cnt <= CNT_W'(COOLDOWN - 1);
                fsm <= COOL;
              end
            end else if (hit_ev[0]) begin
              blue_score  <= blue_score + 1'b1;
              score_pulse <= 2'b01;
`ifdef SCORE_UNDO_EN
              last_scorer <= 2'b01;
`endif
              if (blue_score == LAST_POINT) begin
                winner <= 2'b01;
                fsm    <= WON;
              end else begin
                cnt <= CNT_W'(COOLDOWN - 1);
                fsm <= COOL;
              end
            end
`ifdef SCORE_UNDO_EN
            else if (undo_ev) begin
              if (last_scorer[1] && red_score != '0)
                red_score <= red_score - 1'b1;
              if (last_scorer[0] && blue_score != '0)
                blue_score <= blue_score - 1'b1;
              last_scorer <= '0;
            end
`endif
          end
          COOL: begin
            if (cnt == '0)
              fsm <= PLAY;
            else
              cnt <= cnt - 1'b1;
          end
          default: begin
            // WON holds every tally and the winner until a new game is cleared.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with hand-computed expectations.
`timescale 1ns/1ps
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] color;
  logic [9:0] state;
  logic       clr;
  logic [1:0] score_pulse;
  logic [3:0] red_score;
  logic [3:0] blue_score;
  logic [1:0] winner;
  logic       busy;

  int check_count = 0;
  int error_count = 0;
  int red_pulses  = 0;
  int blue_pulses = 0;

  score_keeper dut (
    .clk(clk), .rst(rst), .color(color), .state(state), .clr(clr),
    .score_pulse(score_pulse), .red_score(red_score), .blue_score(blue_score),
    .winner(winner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Tally of pulse bits seen, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (score_pulse[1]) red_pulses++;
    if (score_pulse[0]) blue_pulses++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic [9:0] s, input logic cl);
    color = c;
    state = s;
    clr   = cl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic single_hit(input logic [9:0] s);
    applyStimulus(3'b100, s, 1'b0);
    tick();
    applyStimulus(3'b000, '0, 1'b0);
    tick();
  endtask

  task automatic clear_game();
    applyStimulus(3'b000, '0, 1'b1);
    tick();
    applyStimulus(3'b000, '0, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(3'b000, '0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_red", 32'(red_score), 0);
    checkOutput("reset_blue", 32'(blue_score), 0);
    checkOutput("reset_winner", 32'(winner), 0);
    checkOutput("reset_pulse", 32'(score_pulse), 0);
    checkOutput("reset_busy", 32'(busy), 0);

    // Single red hit: nothing at the sampling edge, point on the next edge.
    applyStimulus(3'b100, 10'd1 << 2, 1'b0);
    tick();
    applyStimulus(3'b000, '0, 1'b0);
    checkOutput("t1_no_early_pulse", 32'(score_pulse), 0);
    tick();
    checkOutput("t1_pulse", 32'(score_pulse), 32'b10);
    checkOutput("t1_red", 32'(red_score), 1);
    checkOutput("t1_busy0", 32'(busy), 1);
    applyStimulus(3'b100, 10'd1 << 2, 1'b0);
    tick();
    applyStimulus(3'b000, '0, 1'b0);
    checkOutput("t1_pulse_off", 32'(score_pulse), 0);
    checkOutput("t1_busy1", 32'(busy), 1);
    tick();
    checkOutput("t1_busy2", 32'(busy), 1);
    tick();
    checkOutput("t1_busy3", 32'(busy), 1);
    tick();
    checkOutput("t1_busy_done", 32'(busy), 0);
    checkOutput("t1_cool_ignored", 32'(red_score), 1);

    // Asynchronous reset during cooldown returns everything immediately.
    single_hit(10'd1 << 9);
    checkOutput("rst_pre_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy", 32'(busy), 0);
    checkOutput("rst_mid_red", 32'(red_score), 0);
    checkOutput("rst_mid_blue", 32'(blue_score), 0);
    #2 rst = 1'b0;
    tick();

    // Held blue button scores exactly once.
    red_pulses = 0; blue_pulses = 0;
    applyStimulus(3'b100, 10'd1 << 9, 1'b0);
    repeat (20) tick();
    applyStimulus(3'b000, '0, 1'b0);
    repeat (6) tick();
    checkOutput("t2_blue", 32'(blue_score), 1);
    checkOutput("t2_blue_pulses", 32'(blue_pulses), 1);
    checkOutput("t2_red_pulses", 32'(red_pulses), 0);

    // Non-qualifying positions and colours never score.
    clear_game();
    checkOutput("t3_clr_blue", 32'(blue_score), 0);
    red_pulses = 0; blue_pulses = 0;
    applyStimulus(3'b100, 10'b0000000101, 1'b0); repeat (3) tick();
    applyStimulus(3'b110, 10'd1 << 2, 1'b0);     repeat (3) tick();
    applyStimulus(3'b100, 10'd1 << 5, 1'b0);     repeat (3) tick();
    applyStimulus(3'b010, 10'd1 << 9, 1'b0);     repeat (3) tick();
    applyStimulus(3'b100, 10'd0, 1'b0);          repeat (3) tick();
    applyStimulus(3'b000, '0, 1'b0);             repeat (3) tick();
    checkOutput("t3_red", 32'(red_score), 0);
    checkOutput("t3_blue", 32'(blue_score), 0);
    checkOutput("t3_pulses", 32'(red_pulses + blue_pulses), 0);

    // Nine spaced red points win the game; WON freezes until clr.
    red_pulses = 0; blue_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      single_hit(10'd1 << 2);
      repeat (5) tick();
    end
    checkOutput("t4_red", 32'(red_score), 9);
    checkOutput("t4_winner", 32'(winner), 32'b10);
    checkOutput("t4_busy", 32'(busy), 0);
    checkOutput("t4_red_pulses", 32'(red_pulses), 9);
    single_hit(10'd1 << 2);
    repeat (5) tick();
    single_hit(10'd1 << 9);
    repeat (5) tick();
    checkOutput("t4_frozen_red", 32'(red_score), 9);
    checkOutput("t4_frozen_blue", 32'(blue_score), 0);
    checkOutput("t4_frozen_pulses", 32'(red_pulses + blue_pulses), 9);
    clear_game();
    checkOutput("t4_clr_red", 32'(red_score), 0);
    checkOutput("t4_clr_winner", 32'(winner), 0);
    checkOutput("t4_clr_busy", 32'(busy), 0);
    single_hit(10'd1 << 9);
    checkOutput("t4_play_again", 32'(blue_score), 1);
    repeat (5) tick();

    // clr held across the hit's sampling and scoring edges drops the point.
    clear_game();
    red_pulses = 0; blue_pulses = 0;
    applyStimulus(3'b100, 10'd1 << 2, 1'b1);
    tick();
    applyStimulus(3'b000, '0, 1'b1);
    tick();
    applyStimulus(3'b000, '0, 1'b0);
    repeat (5) tick();
    checkOutput("t5_red", 32'(red_score), 0);
    checkOutput("t5_pulses", 32'(red_pulses), 0);
    checkOutput("t5_busy", 32'(busy), 0);

`ifdef SCORE_UNDO_EN
    // Green edge takes back the last point once only.
    single_hit(10'd1 << 2);
    repeat (5) tick();
    checkOutput("t6_red_scored", 32'(red_score), 1);
    applyStimulus(3'b001, '0, 1'b0);
    tick();
    applyStimulus(3'b000, '0, 1'b0);
    repeat (2) tick();
    checkOutput("t6_red_undone", 32'(red_score), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    applyStimulus(3'b001, '0, 1'b0);
    tick();
    applyStimulus(3'b000, '0, 1'b0);
    repeat (2) tick();
    checkOutput("t6_second_undo", 32'(red_score), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
